// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwd_pkg
// Brief    : Shared encodings, slot-record widths and parameter legality
//            helpers for the forwarding / hazard scoreboard.
// Revision : 1.0
// ============================================================================
package fwd_pkg;

    localparam int FWD_REGFILE   = 0;
    localparam int c_SLOT_CTRL_W = 3;   // valid, regwrite, memread

    function automatic int fwd_sel_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int fwd_slot_w(input int reg_addr_w, input int num_src);
        return c_SLOT_CTRL_W + reg_addr_w + num_src * (reg_addr_w + 1);
    endfunction

    function automatic bit fwd_params_legal(input int depth, input int load_ready);
        return (depth >= 2) && (load_ready >= 2) && (load_ready <= depth - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_src_match.sv
`default_nettype none
// ============================================================================
// Module   : fwd_src_match
// Brief    : Youngest-wins priority encoder over slots 1..DEPTH-1 for one
//            source operand address.
// Revision : 1.0
// ============================================================================
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = 2
) (
    input  logic [REG_ADDR_W-1:0]              i_addr,
    input  logic                               i_used,
    input  logic [DEPTH-1:1]                   i_valid,
    input  logic [DEPTH-1:1]                   i_regwrite,
    input  logic [DEPTH-1:1]                   i_memread,
    input  logic [DEPTH-1:1][REG_ADDR_W-1:0]   i_rd,
    output logic [SEL_W-1:0]                   o_sel,
    output logic                               o_early_load
);

    logic [DEPTH-1:1] w_cand;
    logic [DEPTH-1:1] w_hit;

    // A candidate is any live writer of the address; it only becomes a hit
    // when its value exists, i.e. it is not a load still short of LOAD_READY.
    always_comb begin
        w_cand = '0;
        w_hit  = '0;
        for (int k = 1; k < DEPTH; k++) begin
            w_cand[k] = i_used && i_valid[k] && i_regwrite[k] &&
                        (i_rd[k] != '0) && (i_rd[k] == i_addr);
            w_hit[k]  = w_cand[k] && (!i_memread[k] || (k >= LOAD_READY));
        end
    end

    always_comb begin
        o_sel = SEL_W'(FWD_REGFILE);
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (w_hit[k]) begin
                o_sel = SEL_W'(k);
            end
        end
    end

    assign o_early_load = |(w_cand & i_memread & ~w_hit);

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_scoreboard
// Brief    : In-flight destination tag pipeline producing EX forwarding
//            selects, an ID load-use stall and a saturating stall counter.
// Revision : 1.0
// ============================================================================
module fwd_hazard_scoreboard
    import fwd_pkg::*;
#(
    parameter  int REG_ADDR_W = 5,
    parameter  int NUM_SRC    = 2,
    parameter  int DEPTH      = 3,
    parameter  int LOAD_READY = 2,
    parameter  int CNT_W      = 16,
    localparam int SEL_W      = fwd_sel_w(DEPTH)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            issue_valid_i,
    input  logic [REG_ADDR_W-1:0]           issue_rd_i,
    input  logic                            issue_regwrite_i,
    input  logic                            issue_memread_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]   id_src_i,
    input  logic [NUM_SRC-1:0]              id_src_used_i,
    input  logic                            flush_i,
    output logic                            stall_o,
    output logic [NUM_SRC*SEL_W-1:0]        fwd_sel_o,
    output logic [CNT_W-1:0]                stall_cnt_o
);

    if (!fwd_params_legal(DEPTH, LOAD_READY)) begin : g_bad_params
        $error("fwd_hazard_scoreboard: need DEPTH >= 2 and 2 <= LOAD_READY <= DEPTH-1");
    end

    logic [DEPTH-1:0]                    r_valid;
    logic [DEPTH-1:0]                    r_regwrite;
    logic [DEPTH-1:0]                    r_memread;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]    r_rd;
    // Only the EX slot's sources are ever read, so older slots drop them.
    logic [NUM_SRC-1:0][REG_ADDR_W-1:0]  r_ex_src;
    logic [NUM_SRC-1:0]                  r_ex_used;
    logic [CNT_W-1:0]                    r_cnt;

    logic [NUM_SRC-1:0][REG_ADDR_W-1:0]  w_id_src;
    logic                                w_stall;
    logic                                w_bubble;
    logic [NUM_SRC-1:0]                  w_early;

    assign w_id_src = id_src_i;
    assign w_bubble = flush_i || w_stall;

    // Hold ID while a load it needs sits in a slot below LOAD_READY-1.
    always_comb begin
        w_stall = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int j = 0; j <= LOAD_READY - 2; j++) begin
                if (id_src_used_i[s] && r_valid[j] && r_memread[j] &&
                    r_regwrite[j] && (r_rd[j] != '0) && (r_rd[j] == w_id_src[s])) begin
                    w_stall = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid    <= '0;
            r_regwrite <= '0;
            r_memread  <= '0;
            r_rd       <= '0;
            r_ex_src   <= '0;
            r_ex_used  <= '0;
        end else begin
            r_valid    <= {r_valid[DEPTH-2:0],    !w_bubble && issue_valid_i};
            r_regwrite <= {r_regwrite[DEPTH-2:0], !w_bubble && issue_regwrite_i};
            r_memread  <= {r_memread[DEPTH-2:0],  !w_bubble && issue_memread_i};
            r_rd       <= {r_rd[DEPTH-2:0],       w_bubble ? '0 : issue_rd_i};
            r_ex_src   <= w_bubble ? '0 : w_id_src;
            r_ex_used  <= w_bubble ? '0 : id_src_used_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_stall && !flush_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_src_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH),
            .LOAD_READY (LOAD_READY),
            .SEL_W      (SEL_W)
        ) u_match (
            .i_addr       (r_ex_src[s]),
            .i_used       (r_ex_used[s]),
            .i_valid      (r_valid[DEPTH-1:1]),
            .i_regwrite   (r_regwrite[DEPTH-1:1]),
            .i_memread    (r_memread[DEPTH-1:1]),
            .i_rd         (r_rd[DEPTH-1:1]),
            .o_sel        (fwd_sel_o[s*SEL_W +: SEL_W]),
            .o_early_load (w_early[s])
        );
    end

    // A load consumed before LOAD_READY means the stall logic was bypassed.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (w_early == '0)
                else $error("fwd_hazard_scoreboard: load result requested before ready");
        end
    end

    assign stall_o     = w_stall;
    assign stall_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_scoreboard
// Brief    : Directed bench for fwd_hazard_scoreboard, default-shaped and
//            DEPTH=4/LOAD_READY=3/NUM_SRC=3 instances.
// Revision : 1.0
// ============================================================================
module tb_fwd_hazard_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_iv, a_rw, a_mr, a_flush, a_stall;
    logic [4:0]  a_rd;
    logic [9:0]  a_src;
    logic [1:0]  a_used;
    logic [3:0]  a_sel;
    logic [3:0]  a_cnt;

    logic        b_iv, b_rw, b_mr, b_stall;
    logic [4:0]  b_rd;
    logic [14:0] b_src;
    logic [2:0]  b_used;
    logic [5:0]  b_sel;
    logic [15:0] b_cnt;

    int n_total = 0;
    int n_bad   = 0;

    fwd_hazard_scoreboard #(
        .REG_ADDR_W(5), .NUM_SRC(2), .DEPTH(3), .LOAD_READY(2), .CNT_W(4)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .issue_valid_i(a_iv), .issue_rd_i(a_rd), .issue_regwrite_i(a_rw),
        .issue_memread_i(a_mr), .id_src_i(a_src), .id_src_used_i(a_used),
        .flush_i(a_flush), .stall_o(a_stall), .fwd_sel_o(a_sel), .stall_cnt_o(a_cnt)
    );

    fwd_hazard_scoreboard #(
        .REG_ADDR_W(5), .NUM_SRC(3), .DEPTH(4), .LOAD_READY(3), .CNT_W(16)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .issue_valid_i(b_iv), .issue_rd_i(b_rd), .issue_regwrite_i(b_rw),
        .issue_memread_i(b_mr), .id_src_i(b_src), .id_src_used_i(b_used),
        .flush_i(1'b0), .stall_o(b_stall), .fwd_sel_o(b_sel), .stall_cnt_o(b_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_id(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                        input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
        a_iv = v; a_rd = rd; a_rw = rw; a_mr = mr; a_src = {s1, s0}; a_used = used;
    endtask

    task automatic b_id(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                        input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] used);
        b_iv = v; b_rd = rd; b_rw = rw; b_mr = mr; b_src = {s2, s1, s0}; b_used = used;
    endtask

    initial begin
        rst = 1'b1;
        a_flush = 1'b0;
        a_id(0, 0, 0, 0, 0, 0, 2'b00);
        b_id(0, 0, 0, 0, 0, 0, 0, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("init_stall", a_stall, 0);
        check_eq("init_sel",   a_sel,   0);
        check_eq("init_cnt",   a_cnt,   0);
        check_eq("init_cnt_b", b_cnt,   0);

        // back-to-back ALU: add x5; add x6 <- x5,x5; add x7 <- x5
        a_id(1, 5, 1, 0, 1, 2, 2'b11); #1; check_eq("b2b_no_stall", a_stall, 0); tick();
        a_id(1, 6, 1, 0, 5, 5, 2'b11); #1; check_eq("b2b_sel_rf", a_sel, 0); tick();
        a_id(1, 7, 1, 0, 5, 5, 2'b01); #1; check_eq("b2b_both_sel1", a_sel, 4'b0101); tick();
        a_id(0, 0, 0, 0, 0, 0, 2'b00); #1; check_eq("b2b_sel2_unused0", a_sel, 4'b0010); tick();

        // load-use: lw x7; add x8 <- x7,x3
        a_id(1, 7, 1, 1, 1, 0, 2'b01); #1; check_eq("lu_pre_stall", a_stall, 0); tick();
        a_id(1, 8, 1, 0, 7, 3, 2'b11); #1;
        check_eq("lu_stall", a_stall, 1);
        check_eq("lu_cnt_before", a_cnt, 0);
        tick();
        #1;
        check_eq("lu_stall_one_cycle", a_stall, 0);
        check_eq("lu_cnt", a_cnt, 1);
        check_eq("lu_bubble_sel", a_sel, 0);
        tick();
        a_id(1, 9, 1, 0, 8, 0, 2'b01); #1; check_eq("lu_fwd_sel2", a_sel, 4'b0010); tick();
        a_id(0, 0, 0, 0, 0, 0, 2'b00); #1; check_eq("alu_after_load_sel1", a_sel, 4'b0001); tick();

        // priority between two x9 writers, then rd=0 producer and load
        a_id(1, 9, 1, 0, 1, 1, 2'b00); tick();
        a_id(1, 9, 1, 0, 1, 1, 2'b00); tick();
        a_id(1, 0, 1, 0, 9, 0, 2'b11); tick();
        a_id(1, 11, 1, 0, 0, 0, 2'b11); #1; check_eq("prio_youngest", a_sel, 4'b0001); tick();
        a_id(1, 0, 1, 1, 1, 0, 2'b01); #1; check_eq("x0_no_fwd", a_sel, 0); tick();
        a_id(1, 0, 0, 0, 0, 0, 2'b01); #1; check_eq("x0_no_stall", a_stall, 0); tick();

        // flush while stalled
        a_id(1, 12, 1, 1, 1, 0, 2'b01); tick();
        a_id(1, 13, 1, 0, 12, 0, 2'b01); a_flush = 1'b1; #1;
        check_eq("flush_stall", a_stall, 1);
        tick();
        a_flush = 1'b0; #1;
        check_eq("flush_stall_end", a_stall, 0);
        check_eq("flush_no_count", a_cnt, 1);
        tick();
        a_id(0, 0, 0, 0, 0, 0, 2'b00); #1; check_eq("flush_fwd_sel2", a_sel, 4'b0010); tick();

        // plain flush squashes the issuing producer
        a_id(1, 14, 1, 0, 1, 1, 2'b00); a_flush = 1'b1; tick(); a_flush = 1'b0;
        a_id(1, 15, 1, 0, 14, 0, 2'b01); tick();
        a_id(0, 0, 0, 0, 0, 0, 2'b00); #1; check_eq("flush_squash", a_sel, 0); tick();

        // reset mid-operation while a stall is pending
        a_id(1, 20, 1, 1, 1, 0, 2'b01); tick();
        a_id(1, 21, 1, 0, 20, 0, 2'b01); #1;
        check_eq("rst_pre_stall", a_stall, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        check_eq("rst_stall", a_stall, 0);
        check_eq("rst_cnt", a_cnt, 0);
        check_eq("rst_sel", a_sel, 0);
        a_id(0, 0, 0, 0, 0, 0, 2'b00); tick();

        // counter saturation at 15 after 20 load-use stalls
        for (int i = 0; i < 20; i++) begin
            a_id(1, 7, 1, 1, 1, 0, 2'b01); tick();
            a_id(1, 8, 1, 0, 7, 0, 2'b01); tick();
            tick();
            if (i == 4) check_eq("sat_cnt_5", a_cnt, 5);
        end
        check_eq("sat_cnt_hold", a_cnt, 15);
        a_id(0, 0, 0, 0, 0, 0, 2'b00); tick();

        // generalised config: two stall cycles, sel=3 on both used operands
        b_id(1, 7, 1, 1, 1, 0, 0, 3'b001); tick();
        b_id(1, 8, 1, 0, 7, 7, 7, 3'b011); #1; check_eq("g_stall1", b_stall, 1); tick();
        #1; check_eq("g_stall2", b_stall, 1); tick();
        #1;
        check_eq("g_stall_end", b_stall, 0);
        check_eq("g_cnt", b_cnt, 2);
        tick();
        b_id(0, 0, 0, 0, 0, 0, 0, 3'b000); #1;
        check_eq("g_sel3", b_sel, 6'b00_11_11);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
